or1200_cust5_hash_seq: RTL and testbench

- Parametrised l.cust5 hash-accelerator front-end for the OR1200 Keccak extension.
- Decodes the cust5 sub-op, its 6-bit limm index and its operand word, and collects absorb words (start/middle/end) into a block buffer.
- Launches an external permutation core and serves squeeze (store-op) reads by lane index.
- Generalises the fixed 7-word absorb / 16-lane readout path to configurable width, block depth and permutation latency, and adds error reporting and flow control.

---
 rtl/or1200_cust5_hash_pkg.sv | 22 ++
 rtl/or1200_cust5_word_buf.sv | 44 ++++
 rtl/or1200_cust5_hash_seq.sv | 182 ++++++++++++++++++
 tb/tb_or1200_cust5_hash_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_cust5_hash_pkg.sv
// Shared op codes, FSM state type and default sizing for the l.cust5 hash front-end.
package or1200_cust5_hash_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_WORDS = 16;
    localparam int DEF_IDX_W     = 6;

    localparam logic [4:0] OP_RST       = 5'b00000;
    localparam logic [4:0] OP_END       = 5'b00001;
    localparam logic [4:0] OP_MID       = 5'b00010;
    localparam logic [4:0] OP_START     = 5'b00100;
    localparam logic [4:0] OP_START_END = 5'b00101;
    localparam logic [4:0] OP_STORE     = 5'b01000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        PERM   = 2'd2,
        READY  = 2'd3
    } state_t;

endpackage

// File: rtl/or1200_cust5_word_buf.sv
// NUM_WORDS x DATA_W block buffer: clear, indexed (optionally XOR) write, bulk load, flat view.
module or1200_cust5_word_buf
    import or1200_cust5_hash_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int PTR_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic                        wr_xor,
    input  logic [PTR_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        load,
    input  logic [NUM_WORDS*DATA_W-1:0] load_data,
    output logic [NUM_WORDS*DATA_W-1:0] flat
);

    logic [DATA_W-1:0] words [NUM_WORDS];

    // A write in the same cycle as clear lands on a zeroed word, so XOR is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                if (clear)
                    words[i] <= '0;
                else if (load)
                    words[i] <= load_data[i*DATA_W +: DATA_W];
                if (wr_en && wr_idx == PTR_W'(i))
                    words[i] <= (wr_xor && !clear) ? (words[i] ^ wr_data) : wr_data;
            end
        end
    end

    always_comb begin
        flat = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) flat[i*DATA_W +: DATA_W] = words[i];
    end

endmodule

// File: rtl/or1200_cust5_hash_seq.sv
// l.cust5 hash front-end: absorb words into a block, launch the permutation, serve squeeze reads.
// CUST5_HASH_MULTIBLOCK_EN enables chained sponge absorb (MID/END legal in READY).
module or1200_cust5_hash_seq
    import or1200_cust5_hash_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    input  logic [4:0]                  cmd_op,
    input  logic [IDX_W-1:0]            cmd_idx,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic                        cmd_ready,
    output logic                        perm_start,
    output logic [NUM_WORDS*DATA_W-1:0] perm_block,
    input  logic                        perm_done,
    input  logic [NUM_WORDS*DATA_W-1:0] perm_result,
    output logic                        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        busy,
    output logic                        err
);

    localparam int PTR_W = $clog2(NUM_WORDS + 1);
    localparam int SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

`ifdef CUST5_HASH_MULTIBLOCK_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    state_t            state;
    logic [PTR_W-1:0]  wptr;
    logic [DATA_W-1:0] result [NUM_WORDS];

    logic              accept;
    logic              full;
    logic              absorb_ok;
    logic              start_ok;
    logic              buf_clear;
    logic              buf_wr;
    logic              buf_load;
    logic [PTR_W-1:0]  buf_idx;

    assign cmd_ready = (state != PERM);
    assign busy      = (state == PERM);
    assign accept    = cmd_valid && cmd_ready;
    assign full      = (wptr == PTR_W'(NUM_WORDS));
    assign absorb_ok = (state == ABSORB) || (CHAIN && state == READY);
    assign start_ok  = (state == IDLE) || (state == READY);

    // Chained mode: the buffer is preloaded with the result when the core finishes,
    // so every absorb XORs in; a fresh START block XORs into zeros, which is a plain write.
    always_comb begin
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        buf_idx   = wptr;
        buf_load  = CHAIN && (state == PERM) && perm_done;
        if (accept) begin
            case (cmd_op)
                OP_RST: buf_clear = 1'b1;
                OP_START: begin
                    buf_clear = 1'b1;
                    buf_wr    = 1'b1;
                    buf_idx   = '0;
                end
                OP_START_END: begin
                    if (start_ok) begin
                        buf_clear = 1'b1;
                        buf_wr    = 1'b1;
                        buf_idx   = '0;
                    end
                end
                OP_MID, OP_END: buf_wr = absorb_ok && !full;
                default: ;
            endcase
        end
    end

    or1200_cust5_word_buf #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .PTR_W     (PTR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (buf_clear),
        .wr_en     (buf_wr),
        .wr_xor    (CHAIN),
        .wr_idx    (buf_idx),
        .wr_data   (cmd_data),
        .load      (buf_load),
        .load_data (perm_result),
        .flat      (perm_block)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            perm_start <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            err        <= 1'b0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) result[i] <= '0;
        end else begin
            perm_start <= 1'b0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;

            if (state == PERM && perm_done) begin
                for (int unsigned i = 0; i < NUM_WORDS; i++)
                    result[i] <= perm_result[i*DATA_W +: DATA_W];
                state <= READY;
                if (CHAIN) wptr <= '0;
            end

            if (accept) begin
                case (cmd_op)
                    OP_RST: begin
                        state <= IDLE;
                        wptr  <= '0;
                        for (int unsigned i = 0; i < NUM_WORDS; i++) result[i] <= '0;
                    end
                    OP_START: begin
                        state <= ABSORB;
                        wptr  <= PTR_W'(1);
                    end
                    OP_START_END: begin
                        if (start_ok) begin
                            state      <= PERM;
                            wptr       <= PTR_W'(1);
                            perm_start <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_MID: begin
                        if (!absorb_ok) begin
                            err <= 1'b1;
                        end else if (full) begin
                            err <= 1'b1;
                        end else begin
                            wptr  <= wptr + PTR_W'(1);
                            state <= ABSORB;
                        end
                    end
                    OP_END: begin
                        // A full buffer drops the word but still launches the block.
                        if (!absorb_ok) begin
                            err <= 1'b1;
                        end else begin
                            if (full) err <= 1'b1;
                            else      wptr <= wptr + PTR_W'(1);
                            state      <= PERM;
                            perm_start <= 1'b1;
                        end
                    end
                    OP_STORE: begin
                        if (state == READY) begin
                            rd_valid <= 1'b1;
                            if (32'(cmd_idx) < NUM_WORDS) begin
                                rd_data <= result[cmd_idx[SEL_W-1:0]];
                            end else begin
                                rd_data <= '0;
                                err     <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_or1200_cust5_hash_seq.sv
// Self-checking bench for or1200_cust5_hash_seq with a behavioural permutation core and read scoreboard.
module tb_or1200_cust5_hash_seq;

    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 16;
    localparam int IDX_W     = 6;
    localparam int LAT       = 24;

    localparam logic [4:0] C_RST   = 5'b00000;
    localparam logic [4:0] C_END   = 5'b00001;
    localparam logic [4:0] C_MID   = 5'b00010;
    localparam logic [4:0] C_START = 5'b00100;
    localparam logic [4:0] C_SE    = 5'b00101;
    localparam logic [4:0] C_STORE = 5'b01000;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        cmd_valid;
    logic [4:0]                  cmd_op;
    logic [IDX_W-1:0]            cmd_idx;
    logic [DATA_W-1:0]           cmd_data;
    logic                        cmd_ready;
    logic                        perm_start;
    logic [NUM_WORDS*DATA_W-1:0] perm_block;
    logic                        perm_done;
    logic [NUM_WORDS*DATA_W-1:0] perm_result;
    logic                        rd_valid;
    logic [DATA_W-1:0]           rd_data;
    logic                        busy;
    logic                        err;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [DATA_W-1:0] sb [$];

    always #5 clk = ~clk;

    or1200_cust5_hash_seq #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_idx     (cmd_idx),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .perm_start  (perm_start),
        .perm_block  (perm_block),
        .perm_done   (perm_done),
        .perm_result (perm_result),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .err         (err)
    );

    function automatic logic [DATA_W-1:0] core_f(input logic [DATA_W-1:0] w, input int unsigned i);
        return w ^ (32'hA5A50000 | i);
    endfunction

    // Behavioural permutation core: fixed latency, result computed from the launched block.
    initial begin
        logic [NUM_WORDS*DATA_W-1:0] blk;
        perm_done   = 1'b0;
        perm_result = '0;
        forever begin
            @(negedge clk);
            if (perm_start === 1'b1) begin
                blk = perm_block;
                repeat (LAT) @(negedge clk);
                for (int i = 0; i < NUM_WORDS; i++)
                    perm_result[i*DATA_W +: DATA_W] = core_f(blk[i*DATA_W +: DATA_W], i);
                perm_done = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
            end
        end
    end

    // Read scoreboard and launch counter.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (perm_start === 1'b1) start_cnt++;
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%h exp=no_read", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data got=%h exp=%h", rd_data, e);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic issue(input logic [4:0] op, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got=%b exp=1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL perm_timeout got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_idx = '0;
        cmd_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if ({perm_start, rd_valid, err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {perm_start, rd_valid, err}); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
        checks++; if (perm_block !== '0) begin errors++; $display("FAIL rst_block got=%h exp=0", perm_block); end
    endtask

    task automatic test_absorb_squeeze();
        logic [NUM_WORDS*DATA_W-1:0] eb;
        int s0;
        eb = '0;
        s0 = start_cnt;
        issue(C_START, '0, 32'd1);
        eb[0 +: DATA_W] = 32'd1;
        for (int k = 2; k <= 6; k++) begin
            issue(C_MID, '0, DATA_W'(k));
            eb[(k-1)*DATA_W +: DATA_W] = DATA_W'(k);
        end
        issue(C_END, '0, 32'd7);
        eb[6*DATA_W +: DATA_W] = 32'd7;
        checks++; if (perm_start !== 1'b1) begin errors++; $display("FAIL abs_start got=%b exp=1", perm_start); end
        checks++; if (perm_block !== eb) begin errors++; $display("FAIL abs_block got=%h exp=%h", perm_block, eb); end
        checks++; if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL abs_busy got=%b exp=10", {busy, cmd_ready}); end
        wait_idle();
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL abs_start_count got=%0d exp=1", start_cnt - s0); end
        for (int i = NUM_WORDS - 1; i >= 0; i--) begin
            sb.push_back(core_f(eb[i*DATA_W +: DATA_W], i));
            issue(C_STORE, IDX_W'(i), '0);
            checks++; if ({rd_valid, err} !== 2'b10) begin errors++; $display("FAIL abs_read%0d got=%b exp=10", i, {rd_valid, err}); end
        end
    endtask

    task automatic test_busy_flow();
        issue(C_START, '0, 32'h11);
        issue(C_END, '0, 32'h22);
        sb.push_back(core_f(32'h22, 1));
        cmd_valid = 1'b1;
        cmd_op = C_STORE;
        cmd_idx = 6'd1;
        @(negedge clk);
        checks++; if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL busy_hold got=%b exp=01", {cmd_ready, busy}); end
        issue(C_STORE, 6'd1, '0);
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL busy_read got=%b exp=1", rd_valid); end
    endtask

    task automatic test_overflow();
        logic [NUM_WORDS*DATA_W-1:0] eb;
        eb = '0;
        issue(C_START, '0, 32'd100);
        eb[0 +: DATA_W] = 32'd100;
        for (int k = 1; k <= 16; k++) begin
            issue(C_MID, '0, DATA_W'(100 + k));
            if (k < 16) begin
                eb[k*DATA_W +: DATA_W] = DATA_W'(100 + k);
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_mid%0d got=%b exp=0", k, err); end
            end else begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_drop got=%b exp=1", err); end
            end
        end
        issue(C_END, '0, 32'd200);
        checks++; if ({err, perm_start} !== 2'b11) begin errors++; $display("FAIL ovf_end got=%b exp=11", {err, perm_start}); end
        checks++; if (perm_block[15*DATA_W +: DATA_W] !== 32'd115) begin errors++; $display("FAIL ovf_word15 got=%h exp=%h", perm_block[15*DATA_W +: DATA_W], 32'd115); end
        checks++; if (perm_block !== eb) begin errors++; $display("FAIL ovf_block got=%h exp=%h", perm_block, eb); end
        wait_idle();
    endtask

    task automatic test_illegal();
        sb.push_back('0);
        issue(C_STORE, 6'd63, '0);
        checks++; if ({rd_valid, err} !== 2'b11) begin errors++; $display("FAIL bad_idx got=%b exp=11", {rd_valid, err}); end
        issue(C_RST, '0, '0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_op_err got=%b exp=0", err); end
        issue(C_MID, '0, 32'h5);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b exp=1", err); end
        issue(C_STORE, '0, '0);
        checks++; if ({rd_valid, err} !== 2'b01) begin errors++; $display("FAIL store_idle got=%b exp=01", {rd_valid, err}); end
        issue(5'b10000, '0, '0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_op got=%b exp=1", err); end
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL idle_state got=%b exp=10", {cmd_ready, busy}); end
    endtask

    task automatic test_single_word();
        logic [NUM_WORDS*DATA_W-1:0] eb;
        eb = '0;
        eb[0 +: DATA_W] = 32'hDEADBEEF;
        issue(C_SE, '0, 32'hDEADBEEF);
        checks++; if (perm_start !== 1'b1) begin errors++; $display("FAIL se_start got=%b exp=1", perm_start); end
        checks++; if (perm_block !== eb) begin errors++; $display("FAIL se_block got=%h exp=%h", perm_block, eb); end
        wait_idle();
        sb.push_back(core_f(32'hDEADBEEF, 0));
        issue(C_STORE, 6'd0, '0);
        sb.push_back(core_f('0, 5));
        issue(C_STORE, 6'd5, '0);
`ifdef CUST5_HASH_MULTIBLOCK_EN
        for (int i = 0; i < NUM_WORDS; i++)
            eb[i*DATA_W +: DATA_W] = core_f(eb[i*DATA_W +: DATA_W], i);
        eb[0 +: DATA_W] = eb[0 +: DATA_W] ^ 32'h1;
        eb[DATA_W +: DATA_W] = eb[DATA_W +: DATA_W] ^ 32'h2;
        issue(C_MID, '0, 32'h1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chain_mid got=%b exp=0", err); end
        issue(C_END, '0, 32'h2);
        checks++; if (perm_block[0 +: DATA_W] !== (core_f(32'hDEADBEEF, 0) ^ 32'h1)) begin errors++; $display("FAIL chain_word0 got=%h exp=%h", perm_block[0 +: DATA_W], core_f(32'hDEADBEEF, 0) ^ 32'h1); end
        checks++; if (perm_block !== eb) begin errors++; $display("FAIL chain_block got=%h exp=%h", perm_block, eb); end
        wait_idle();
`else
        issue(C_MID, '0, 32'h1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", err); end
        sb.push_back(core_f(32'hDEADBEEF, 0));
        issue(C_STORE, 6'd0, '0);
`endif
    endtask

    task automatic test_reset_mid_perm();
        issue(C_START, '0, 32'h5);
        issue(C_END, '0, 32'h6);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rp_busy got=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rp_async got=%b exp=10", {cmd_ready, busy}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        checks++; if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL rp_idle got=%b exp=10", {cmd_ready, busy}); end
        issue(C_STORE, '0, '0);
        checks++; if ({rd_valid, err} !== 2'b01) begin errors++; $display("FAIL rp_store got=%b exp=01", {rd_valid, err}); end
    endtask

    initial begin
        test_reset();
        test_absorb_squeeze();
        test_busy_flow();
        test_overflow();
        test_illegal();
        test_single_word();
        test_reset_mid_perm();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
